// File: rtl/d_latch_pkg.sv
// Shared constants for the clocked D-latch emulation block.
package d_latch_pkg;

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MAX_WIDTH = 64;

endpackage : d_latch_pkg

// File: rtl/d_latch_cell.sv
// One bit of clocked latch emulation: loads d on a rising edge while enable is high, else holds.
// Latency: 1 cycle load. Backpressure: none; output always valid, q_bar is always the complement of q.
module d_latch_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic enable,
    output logic q,
    output logic q_bar
);

    localparam logic RST_VAL = 1'b0;

    logic store_d;
    logic store_q;

    always_comb begin
        store_d = store_q;
        if (enable) begin
            store_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= RST_VAL;
        end else begin
            store_q <= store_d;
        end
    end

    // Both outputs come straight off the flop so they can never disagree.
    assign q     = store_q;
    assign q_bar = ~store_q;

endmodule : d_latch_cell

// File: rtl/d_latch.sv
// Clock-domain D latch with complementary outputs, built from one flop cell per bit.
// Latency: 1 cycle from D at an enabled edge to Q. Backpressure: none; Q/Q_bar always valid.
module d_latch
    import d_latch_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] D,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    input  logic             clk,
    input  logic             rst
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("d_latch: WIDTH out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_latch_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .d      (D[i]),
            .enable (enable),
            .q      (Q[i]),
            .q_bar  (Q_bar[i])
        );
    end

endmodule : d_latch

// File: tb/tb_d_latch.sv
// Scoreboard bench for d_latch at WIDTH=1 and WIDTH=8 driven side by side.
module tb_d_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1, en1, q1, qb1;
    logic [7:0] d8, q8, qb8;
    logic       en8;

    logic       m1;
    logic [7:0] m8;
    logic       sb1[$];
    logic [7:0] sb8[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    d_latch #(.WIDTH(1)) dut1 (
        .D(d1), .enable(en1), .Q(q1), .Q_bar(qb1), .clk(clk), .rst(rst)
    );

    d_latch #(.WIDTH(8)) dut8 (
        .D(d8), .enable(en8), .Q(q8), .Q_bar(qb8), .clk(clk), .rst(rst)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check(input string tag);
        logic       e1, ne1;
        logic [7:0] e8, ne8;
        e1  = sb1.pop_front();
        e8  = sb8.pop_front();
        ne1 = ~e1;
        ne8 = ~e8;
        check({tag, "_q1"},  {63'b0, q1},  {63'b0, e1});
        check({tag, "_qb1"}, {63'b0, qb1}, {63'b0, ne1});
        check({tag, "_q8"},  {56'b0, q8},  {56'b0, e8});
        check({tag, "_qb8"}, {56'b0, qb8}, {56'b0, ne8});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q1"},  {63'b0, q1},  64'd0);
        check({tag, "_qb1"}, {63'b0, qb1}, 64'd1);
        check({tag, "_q8"},  {56'b0, q8},  64'd0);
        check({tag, "_qb8"}, {56'b0, qb8}, 64'hff);
    endtask

    // Drive at the falling edge, record the model's expectation, compare just after the rising edge.
    task automatic step(input string tag, input logic nd1, input logic nen1,
                        input logic [7:0] nd8, input logic nen8);
        @(negedge clk);
        d1 = nd1; en1 = nen1; d8 = nd8; en8 = nen8;
        if (nen1) m1 = nd1;
        if (nen8) m8 = nd8;
        sb1.push_back(m1);
        sb8.push_back(m8);
        @(posedge clk);
        #1;
        pop_and_check(tag);
    endtask

    initial begin
        rst = 1'b1;
        d1 = 1'b0; en1 = 1'b0; d8 = 8'h00; en8 = 1'b0;
        m1 = 1'b0; m8 = 8'h00;
        #2;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        step("preload", 1'b1, 1'b1, 8'h3c, 1'b1);

        // Mid-cycle reset with enable and D high must clear immediately and stay cleared.
        @(posedge clk);
        #2;
        d1 = 1'b1; en1 = 1'b1; d8 = 8'hff; en8 = 1'b1;
        rst = 1'b1;
        m1 = 1'b0; m8 = 8'h00;
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        en1 = 1'b0; en8 = 1'b0;
        rst = 1'b0;

        step("hold0", 1'b0, 1'b0, 8'h00, 1'b0);
        step("hold1", 1'b1, 1'b0, 8'hff, 1'b0);
        step("hold2", 1'b0, 1'b0, 8'h00, 1'b0);

        step("xp_rise", 1'b1, 1'b1, 8'h81, 1'b1);
        step("xp_keep", 1'b1, 1'b1, 8'h81, 1'b1);
        step("xp_fall", 1'b0, 1'b1, 8'h18, 1'b1);

        // Glitch on D between edges: only the value at the edge may be stored.
        @(negedge clk);
        d1 = 1'b1; d8 = 8'hff;
        #1;
        d1 = 1'b0; d8 = 8'h18;
        @(posedge clk);
        #1;
        check("glitch_q1", {63'b0, q1}, 64'd0);
        check("glitch_q8", {56'b0, q8}, 64'h18);

        step("cap_load", 1'b1, 1'b1, 8'ha5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("cap_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        check("wide_qb8", {56'b0, qb8}, 64'h5a);

        // Reset released on the same edge that would load: reset must win that edge.
        @(negedge clk);
        rst = 1'b1;
        m1 = 1'b0; m8 = 8'h00;
        d1 = 1'b1; en1 = 1'b1; d8 = 8'hc3; en8 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        rst <= 1'b0;
        sb1.push_back(m1);
        sb8.push_back(m8);
        #1;
        pop_and_check("coll_edge");
        step("coll_next", 1'b1, 1'b1, 8'hc3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_d_latch
